regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 153 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: walks one ALU operation through the regfile bus:
// select indices, read A and B, hand operands to the ALU, then write back the result and optional flags.
module regfile_sequencer #(
    parameter int WORD_WIDTH  = 16,
    parameter int INDEX_WIDTH = 3,
    parameter int CMD_WIDTH   = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [INDEX_WIDTH-1:0] i_idx_a,
    input  logic [INDEX_WIDTH-1:0] i_idx_b,
    input  logic [INDEX_WIDTH-1:0] i_idx_c,
    input  logic                   i_write_flags,
    output logic                   o_op_valid,
    input  logic                   i_op_ready,
    output logic [WORD_WIDTH-1:0]  o_op_a,
    output logic [WORD_WIDTH-1:0]  o_op_b,
    input  logic                   i_res_valid,
    input  logic [WORD_WIDTH-1:0]  i_res_data,
    input  logic [7:0]             i_res_flags,
    output logic                   o_bus_valid,
    output logic [CMD_WIDTH-1:0]   o_bus_command,
    output logic [WORD_WIDTH-1:0]  o_bus_data,
    input  logic                   i_bus_valid,
    input  logic [WORD_WIDTH-1:0]  i_bus_data,
    output logic                   o_done,
    output logic                   o_error
);
    localparam logic [CMD_WIDTH-1:0] COM_NOP      = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHSEL = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] COM_READA    = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] COM_READB    = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHC   = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHF   = CMD_WIDTH'(5);

    if (3 * INDEX_WIDTH > WORD_WIDTH) begin : g_bad_width
        $error("three packed indices must fit in one data word");
    end

    typedef enum logic [3:0] {IDLE, SEL, RDA, RDB, OP, WAIT, WRC, WRF, DONE} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_a_q, idx_a_d, idx_b_q, idx_b_d, idx_c_q, idx_c_d;
    logic                   wflags_q, wflags_d;
    logic [WORD_WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic [7:0]             flags_q, flags_d;

    assign o_op_a = op_a_q;
    assign o_op_b = op_b_q;

    always_comb begin
        state_d       = state_q;
        idx_a_d       = idx_a_q;
        idx_b_d       = idx_b_q;
        idx_c_d       = idx_c_q;
        wflags_d      = wflags_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        res_d         = res_q;
        flags_d       = flags_q;
        o_req_ready   = 1'b0;
        o_op_valid    = 1'b0;
        o_bus_valid   = 1'b0;
        o_bus_command = COM_NOP;
        o_bus_data    = '0;
        o_done        = 1'b0;
        o_error       = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    idx_a_d  = i_idx_a;
                    idx_b_d  = i_idx_b;
                    idx_c_d  = i_idx_c;
                    wflags_d = i_write_flags;
                    state_d  = SEL;
                end
            end
            SEL: begin
                o_bus_valid   = 1'b1;
                o_bus_command = COM_LATCHSEL;
                o_bus_data    = WORD_WIDTH'({idx_c_q, idx_b_q, idx_a_q});
                state_d       = RDA;
            end
            RDA: begin
                o_bus_command = COM_READA;
                op_a_d        = i_bus_valid ? i_bus_data : op_a_q;
                o_error       = !i_bus_valid;
                state_d       = i_bus_valid ? RDB : IDLE;
            end
            RDB: begin
                o_bus_command = COM_READB;
                op_b_d        = i_bus_valid ? i_bus_data : op_b_q;
                o_error       = !i_bus_valid;
                state_d       = i_bus_valid ? OP : IDLE;
            end
            OP: begin
                o_op_valid = 1'b1;
                state_d    = i_op_ready ? WAIT : OP;
            end
            WAIT: begin
                if (i_res_valid) begin
                    res_d   = i_res_data;
                    flags_d = i_res_flags;
                    state_d = WRC;
                end
            end
            WRC: begin
                o_bus_valid   = 1'b1;
                o_bus_command = COM_LATCHC;
                o_bus_data    = res_q;
                state_d       = wflags_q ? WRF : DONE;
            end
            WRF: begin
                o_bus_valid   = 1'b1;
                o_bus_command = COM_LATCHF;
                o_bus_data    = WORD_WIDTH'(flags_q);
                state_d       = DONE;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= IDLE;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            idx_c_q  <= '0;
            wflags_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_a_q  <= idx_a_d;
            idx_b_q  <= idx_b_d;
            idx_c_q  <= idx_c_d;
            wflags_q <= wflags_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: randomized operations against a bench regfile/ALU and a behavioural register model.
module tb_regfile_sequencer;
    localparam logic [2:0] COM_NOP = 3'd0, COM_LATCHSEL = 3'd1, COM_READA = 3'd2,
                           COM_READB = 3'd3, COM_LATCHC = 3'd4, COM_LATCHF = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, o_req_ready, i_write_flags;
    logic [2:0]  i_idx_a, i_idx_b, i_idx_c;
    logic        o_op_valid, i_op_ready, i_res_valid;
    logic [15:0] o_op_a, o_op_b, i_res_data;
    logic [7:0]  i_res_flags;
    logic        o_bus_valid, i_bus_valid;
    logic [2:0]  o_bus_command;
    logic [15:0] o_bus_data, i_bus_data;
    logic        o_done, o_error;

    logic [15:0] rf [8];
    logic [15:0] exp_rf [8];
    logic [15:0] rf_f = '0;
    logic [2:0]  sel_a = '0, sel_b = '0, sel_c = '0;
    logic [18:0] log_q [$];
    int          bad_mode = 0;
    int          errors = 0, checks = 0;

    regfile_sequencer dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_idx_a(i_idx_a), .i_idx_b(i_idx_b), .i_idx_c(i_idx_c), .i_write_flags(i_write_flags),
        .o_op_valid(o_op_valid), .i_op_ready(i_op_ready), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .i_res_valid(i_res_valid), .i_res_data(i_res_data), .i_res_flags(i_res_flags),
        .o_bus_valid(o_bus_valid), .o_bus_command(o_bus_command), .o_bus_data(o_bus_data),
        .i_bus_valid(i_bus_valid), .i_bus_data(i_bus_data), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    // Bench regfile: reads answer combinationally; r0 is hard-wired to zero.
    assign i_bus_valid = (o_bus_command == COM_READA && bad_mode != 1) ||
                         (o_bus_command == COM_READB && bad_mode != 2);
    assign i_bus_data  = (o_bus_command == COM_READA) ? rf[sel_a] : rf[sel_b];
    assign i_res_data  = o_op_a + o_op_b;

    always @(negedge clk) begin
        if (o_bus_valid) begin
            log_q.push_back({o_bus_command, o_bus_data});
            if (o_bus_command == COM_LATCHSEL) {sel_c, sel_b, sel_a} = o_bus_data[8:0];
            else if (o_bus_command == COM_LATCHC && sel_c != 3'd0) rf[sel_c] = o_bus_data;
            else if (o_bus_command == COM_LATCHF) rf_f = o_bus_data;
        end
    end

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    task automatic run_op(input int a, input int b, input int c, input int wf, input logic [7:0] fl,
                          input int so, input int sr, input int bad, input int noise);
        int n, oc, wc, went, exp_n;
        logic [15:0] ea, eb, er;
        ea = exp_rf[a];
        eb = exp_rf[b];
        er = ea + eb;
        @(negedge clk);
        i_idx_a = 3'(a); i_idx_b = 3'(b); i_idx_c = 3'(c); i_write_flags = wf[0];
        i_res_flags = fl; i_op_ready = (so == 0); i_res_valid = (sr == 0);
        bad_mode = bad; i_req_valid = 1'b1; log_q.delete();
        checks++;
        if (o_req_ready !== 1'b1) begin errors++; $display("FAIL req_ready got=%b exp=1", o_req_ready); end
        n = 0; oc = 0; wc = 0; went = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (noise != 0) begin
                    i_idx_a = 3'($urandom); i_idx_b = 3'($urandom); i_idx_c = 3'($urandom);
                    i_write_flags = ~wf[0];
                end else i_req_valid = 1'b0;
            end
            if (o_done || o_error) break;
            if (o_op_valid) begin
                checks += 3;
                if (o_op_a !== ea) begin errors++; $display("FAIL op_a got=%h exp=%h", o_op_a, ea); end
                if (o_op_b !== eb) begin errors++; $display("FAIL op_b got=%h exp=%h", o_op_b, eb); end
                if (o_bus_valid !== 1'b0 || o_bus_command !== COM_NOP) begin
                    errors++; $display("FAIL op_bus_idle got=%b/%0d exp=0/%0d", o_bus_valid, o_bus_command, COM_NOP);
                end
                oc++;
                if (oc >= so) i_op_ready = 1'b1;
                went = 1;
            end else if (went != 0) begin
                wc++;
                if (wc >= sr) i_res_valid = 1'b1;
            end
        end
        i_req_valid = 1'b0;
        checks++;
        if (n >= 200) begin errors++; $display("FAIL op_timeout got=%0d cycles exp=<200", n); end
        if (bad != 0) begin
            checks += 3;
            if (o_error !== 1'b1 || o_done !== 1'b0) begin
                errors++; $display("FAIL err_pulse got=%b/%b exp=1/0", o_error, o_done);
            end
            if (n !== bad + 1) begin errors++; $display("FAIL err_cycle got=%0d exp=%0d", n, bad + 1); end
            if (log_q.size() !== 1) begin errors++; $display("FAIL err_writes got=%0d exp=1", log_q.size()); end
        end else begin
            exp_n = 5 + wf + at_least_one(so) + at_least_one(sr);
            checks += 4;
            if (o_done !== 1'b1) begin errors++; $display("FAIL done got=%b exp=1", o_done); end
            if (n !== exp_n) begin errors++; $display("FAIL latency got=%0d exp=%0d", n, exp_n); end
            if (log_q.size() !== 2 + wf) begin
                errors++; $display("FAIL write_count got=%0d exp=%0d", log_q.size(), 2 + wf);
            end else begin
                if (log_q[0] !== {COM_LATCHSEL, 16'((c << 6) | (b << 3) | a)}) begin
                    errors++; $display("FAIL sel_write got=%h exp=%h", log_q[0], {COM_LATCHSEL, 16'((c << 6) | (b << 3) | a)});
                end
                if (log_q[1] !== {COM_LATCHC, er}) begin
                    errors++; $display("FAIL c_write got=%h exp=%h", log_q[1], {COM_LATCHC, er});
                end
                if (wf != 0) begin
                    checks++;
                    if (log_q[2] !== {COM_LATCHF, 8'h00, fl}) begin
                        errors++; $display("FAIL f_write got=%h exp=%h", log_q[2], {COM_LATCHF, 8'h00, fl});
                    end
                end
            end
            if (c != 0) exp_rf[c] = er;
            if (rf[c] !== exp_rf[c]) begin errors++; $display("FAIL reg_value got=%h exp=%h", rf[c], exp_rf[c]); end
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_error !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++; $display("FAIL pulse_end got=%b%b%b exp=001", o_done, o_error, o_req_ready);
        end
        bad_mode = 0;
    endtask

    task automatic check_cleared(input string tag);
        checks += 6;
        if (o_op_a !== 16'h0) begin errors++; $display("FAIL %s_op_a got=%h exp=0", tag, o_op_a); end
        if (o_op_b !== 16'h0) begin errors++; $display("FAIL %s_op_b got=%h exp=0", tag, o_op_b); end
        if (o_op_valid !== 1'b0) begin errors++; $display("FAIL %s_op_valid got=%b exp=0", tag, o_op_valid); end
        if (o_bus_valid !== 1'b0) begin errors++; $display("FAIL %s_bus_valid got=%b exp=0", tag, o_bus_valid); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL %s_done got=%b exp=0", tag, o_done); end
        if (o_error !== 1'b0) begin errors++; $display("FAIL %s_error got=%b exp=0", tag, o_error); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req_valid = 1'b0; i_idx_a = '0; i_idx_b = '0; i_idx_c = '0;
        i_write_flags = 1'b0; i_op_ready = 1'b0; i_res_valid = 1'b0; i_res_flags = '0;
        for (int i = 0; i < 8; i++) begin
            rf[i] = (i == 0) ? 16'h0 : 16'($urandom);
            exp_rf[i] = rf[i];
        end
        rf[1] = 16'h0005; exp_rf[1] = 16'h0005;
        rf[2] = 16'h0007; exp_rf[2] = 16'h0007;
        #12;
        check_cleared("reset");
        checks++;
        if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(1, 2, 3, 0, 8'h00, 0, 0, 0, 0);
        run_op(1, 2, 3, 1, 8'hA5, 0, 0, 0, 0);
    endtask

    task automatic test_read_error();
        run_op(1, 2, 5, 0, 8'h3C, 0, 0, 1, 0);
        run_op(2, 1, 5, 1, 8'h3C, 0, 0, 2, 1);
    endtask

    task automatic test_op_stall();
        run_op(3, 4, 6, 1, 8'h5A, 10, 0, 0, 1);
        run_op(6, 3, 7, 0, 8'h11, 2, 5, 0, 0);
    endtask

    task automatic test_c_zero();
        run_op(1, 2, 0, 0, 8'h00, 0, 0, 0, 0);
        run_op(0, 1, 4, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_reset_in_wait();
        int n;
        @(negedge clk);
        i_idx_a = 3'd1; i_idx_b = 3'd2; i_idx_c = 3'd4; i_write_flags = 1'b1;
        i_op_ready = 1'b1; i_res_valid = 1'b0; i_req_valid = 1'b1; log_q.delete();
        @(negedge clk);
        i_req_valid = 1'b0;
        n = 0;
        while (!o_op_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (o_op_valid !== 1'b1) begin errors++; $display("FAIL rw_reach_op got=%b exp=1", o_op_valid); end
        repeat (2) @(negedge clk);
        checks++;
        if (o_op_a !== exp_rf[1]) begin errors++; $display("FAIL rw_pre_op_a got=%h exp=%h", o_op_a, exp_rf[1]); end
        #2 rst_n = 1'b0;
        i_res_valid = 1'b1;
        #1 check_cleared("rw");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        i_res_valid = 1'b0;
        checks += 3;
        if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rw_idle got=%b exp=1", o_req_ready); end
        if (log_q.size() !== 1) begin errors++; $display("FAIL rw_writes got=%0d exp=1", log_q.size()); end
        if (rf[4] !== exp_rf[4]) begin errors++; $display("FAIL rw_reg got=%h exp=%h", rf[4], exp_rf[4]); end
        run_op(2, 2, 5, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 30; k++) begin
            run_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                   8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0, $urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_error();
        test_op_stall();
        test_c_zero();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
